// File: rtl/grid_ray_walker.sv
// Walks a ray across vertical or horizontal grid lines and probes an external 1-cycle map port.
// Define GRID_RAY_WALKER_STEP_LIMIT_EN to add step_limit_hit and cap the walk at MAX_STEPS candidates.
module grid_ray_walker #(
  parameter int COORD_W   = 13,
  parameter int LOG2_TILE = 6,
  parameter int GRID_DIM  = 64,
  parameter int FRAC_BITS = 8,
  parameter int MAX_STEPS = 64
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             begin_calc,
  input  logic                             axis_sel,
  input  logic                             dir_neg,
  input  logic [COORD_W-1:0]               player_x,
  input  logic [COORD_W-1:0]               player_y,
  input  logic [COORD_W+FRAC_BITS-1:0]     slope,
  output logic                             grid_rd,
  output logic [2*$clog2(GRID_DIM)-1:0]    grid_addr,
  input  logic                             grid_data,
  output logic                             busy,
  output logic [COORD_W-1:0]               wall_x,
  output logic [COORD_W-1:0]               wall_y,
  output logic                             wall_found,
  output logic                             bounds_reached,
  output logic [$clog2(MAX_STEPS):0]       step_count,
  output logic                             end_calc
`ifdef GRID_RAY_WALKER_STEP_LIMIT_EN
  ,
  output logic                             step_limit_hit
`endif
);

  localparam int IW   = COORD_W + 2;
  localparam int SW   = COORD_W + FRAC_BITS;
  localparam int PW   = IW + SW;
  localparam int GLOG = $clog2(GRID_DIM);
  localparam int SCW  = $clog2(MAX_STEPS) + 1;
  localparam logic signed [IW-1:0] TILE      = IW'(2 ** LOG2_TILE);
  localparam logic signed [IW-1:0] TILE_MASK = ~IW'(2 ** LOG2_TILE - 1);
  localparam logic signed [IW-1:0] EXTENT    = IW'(GRID_DIM * (2 ** LOG2_TILE));
  localparam logic signed [IW-1:0] ONE       = IW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_FIRST_P, S_FIRST_S, S_OFFSET, S_ADDR, S_WAIT, S_EVAL, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic                 axis_q, axis_d, neg_q, neg_d, hit_q, hit_d;
  logic                 found_q, found_d, bounds_q, bounds_d;
  logic [SW-1:0]        slope_q, slope_d;
  logic signed [IW-1:0] pp_q, pp_d, ps_q, ps_d, cp_q, cp_d, cs_q, cs_d;
  logic signed [IW-1:0] dp_q, dp_d, ds_q, ds_d;
  logic [COORD_W-1:0]   wx_q, wx_d, wy_q, wy_d;
  logic [SCW-1:0]       sc_q, sc_d;
`ifdef GRID_RAY_WALKER_STEP_LIMIT_EN
  logic                 limit_q, limit_d;
`endif

  logic [COORD_W-1:0]   sel_p, sel_s;
  logic signed [IW-1:0] step_p, mul_a, scaled, base_p, x_c, y_c;
  logic signed [PW-1:0] mul_a_ext, mul_b_ext, prod;
  logic                 in_range;
  logic                 unused_prod_bits;

  assign sel_p  = axis_sel ? player_y : player_x;
  assign sel_s  = axis_sel ? player_x : player_y;
  assign step_p = neg_q ? -TILE : TILE;

  // One multiplier serves both s0 (p0-p)*slope and ds dp*slope; slicing at FRAC_BITS is the floor shift.
  assign mul_a     = (state_q == S_FIRST_S) ? (cp_q - pp_q) : step_p;
  assign mul_a_ext = {{(PW-IW){mul_a[IW-1]}}, mul_a};
  assign mul_b_ext = {{(PW-SW){slope_q[SW-1]}}, slope_q};
  assign prod      = mul_a_ext * mul_b_ext;
  assign scaled    = prod[FRAC_BITS +: IW];
  assign unused_prod_bits = ^{prod[PW-1:FRAC_BITS+IW], prod[FRAC_BITS-1:0]};

  assign base_p   = pp_q & TILE_MASK;
  assign x_c      = axis_q ? cs_q : cp_q;
  assign y_c      = axis_q ? cp_q : cs_q;
  assign in_range = !x_c[IW-1] && !y_c[IW-1] && (x_c < EXTENT) && (y_c < EXTENT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      axis_q   <= 1'b0;
      neg_q    <= 1'b0;
      hit_q    <= 1'b0;
      found_q  <= 1'b0;
      bounds_q <= 1'b0;
      slope_q  <= '0;
      pp_q     <= '0;
      ps_q     <= '0;
      cp_q     <= '0;
      cs_q     <= '0;
      dp_q     <= '0;
      ds_q     <= '0;
      wx_q     <= '0;
      wy_q     <= '0;
      sc_q     <= '0;
`ifdef GRID_RAY_WALKER_STEP_LIMIT_EN
      limit_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      axis_q   <= axis_d;
      neg_q    <= neg_d;
      hit_q    <= hit_d;
      found_q  <= found_d;
      bounds_q <= bounds_d;
      slope_q  <= slope_d;
      pp_q     <= pp_d;
      ps_q     <= ps_d;
      cp_q     <= cp_d;
      cs_q     <= cs_d;
      dp_q     <= dp_d;
      ds_q     <= ds_d;
      wx_q     <= wx_d;
      wy_q     <= wy_d;
      sc_q     <= sc_d;
`ifdef GRID_RAY_WALKER_STEP_LIMIT_EN
      limit_q  <= limit_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    axis_d    = axis_q;
    neg_d     = neg_q;
    hit_d     = hit_q;
    found_d   = found_q;
    bounds_d  = bounds_q;
    slope_d   = slope_q;
    pp_d      = pp_q;
    ps_d      = ps_q;
    cp_d      = cp_q;
    cs_d      = cs_q;
    dp_d      = dp_q;
    ds_d      = ds_q;
    wx_d      = wx_q;
    wy_d      = wy_q;
    sc_d      = sc_q;
`ifdef GRID_RAY_WALKER_STEP_LIMIT_EN
    limit_d   = limit_q;
`endif
    grid_rd   = 1'b0;
    grid_addr = '0;

    case (state_q)
      S_IDLE: begin
        if (begin_calc) begin
          axis_d   = axis_sel;
          neg_d    = dir_neg;
          slope_d  = slope;
          pp_d     = {{2{sel_p[COORD_W-1]}}, sel_p};
          ps_d     = {{2{sel_s[COORD_W-1]}}, sel_s};
          found_d  = 1'b0;
          bounds_d = 1'b0;
          sc_d     = '0;
`ifdef GRID_RAY_WALKER_STEP_LIMIT_EN
          limit_d  = 1'b0;
`endif
          state_d  = S_FIRST_P;
        end
      end
      S_FIRST_P: begin
        cp_d    = neg_q ? (base_p - ONE) : (base_p + TILE);
        state_d = S_FIRST_S;
      end
      S_FIRST_S: begin
        cs_d    = ps_q + scaled;
        state_d = S_OFFSET;
      end
      S_OFFSET: begin
        dp_d    = step_p;
        ds_d    = scaled;
        state_d = S_ADDR;
      end
      S_ADDR: begin
        wx_d = x_c[COORD_W-1:0];
        wy_d = y_c[COORD_W-1:0];
        if (!in_range) begin
          bounds_d = 1'b1;
          state_d  = S_DONE;
        end else begin
          grid_rd   = 1'b1;
          grid_addr = {y_c[LOG2_TILE +: GLOG], x_c[LOG2_TILE +: GLOG]};
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        // Map data is only guaranteed valid here, so capture it for S_EVAL.
        hit_d   = grid_data;
        state_d = S_EVAL;
      end
      S_EVAL: begin
        wx_d = x_c[COORD_W-1:0];
        wy_d = y_c[COORD_W-1:0];
        sc_d = sc_q + SCW'(1);
        if (hit_q) begin
          found_d = 1'b1;
          state_d = S_DONE;
        end
`ifdef GRID_RAY_WALKER_STEP_LIMIT_EN
        else if (sc_d == SCW'(MAX_STEPS)) begin
          limit_d = 1'b1;
          state_d = S_DONE;
        end
`endif
        else begin
          cp_d    = cp_q + dp_q;
          cs_d    = cs_q + ds_q;
          state_d = S_ADDR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy           = (state_q != S_IDLE);
  assign end_calc       = (state_q == S_DONE);
  assign wall_x         = wx_q;
  assign wall_y         = wy_q;
  assign wall_found     = found_q;
  assign bounds_reached = bounds_q;
  assign step_count     = sc_q;
`ifdef GRID_RAY_WALKER_STEP_LIMIT_EN
  assign step_limit_hit = limit_q;
`endif

endmodule
